// File: rtl/lookup_table_write_pkg.sv
// Shared definitions for the lookup-table writer: flush FSM encoding and skid FIFO sizing.
package lookup_table_write_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    STREAM = 2'd2
  } flush_state_t;

  localparam int unsigned FIFO_DEPTH = 2;
  localparam int unsigned FIFO_PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned FIFO_CNT_W = $clog2(FIFO_DEPTH + 1);

endpackage

// File: rtl/lookup_table_write_fill_addr_gen.sv
// Fill address pattern generator: after delay cycles, sweeps iter periods of per cycles,
// enabling a write in the first duty cycles of each period.
module fill_addr_gen #(
  parameter int unsigned ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              running,
  input  logic [31:0]       delay,
  input  logic [ADDR_W-1:0] iter,
  input  logic [ADDR_W-1:0] per,
  input  logic [ADDR_W-1:0] duty,
  input  logic [ADDR_W-1:0] shift,
  input  logic [ADDR_W-1:0] incr,
  output logic [ADDR_W-1:0] addr,
  output logic              en,
  output logic              done
);

  logic              busy;
  logic [31:0]       dly_cnt;
  logic [ADDR_W-1:0] per_cnt;
  logic [ADDR_W-1:0] iter_cnt;
  logic              active;
  logic              period_end;

  always_comb begin
    active     = busy && running && (dly_cnt == '0);
    period_end = (per_cnt == per - 1'b1);
    en         = active && (per_cnt < duty);
  end

  // shift is applied on top of the step taken in the last cycle of each period
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy     <= 1'b0;
      done     <= 1'b1;
      dly_cnt  <= '0;
      per_cnt  <= '0;
      iter_cnt <= '0;
      addr     <= '0;
    end else if (start) begin
      busy     <= (iter != '0) && (per != '0);
      done     <= (iter == '0) || (per == '0);
      dly_cnt  <= delay;
      per_cnt  <= '0;
      iter_cnt <= '0;
      addr     <= '0;
    end else if (busy && running) begin
      if (dly_cnt != '0) begin
        dly_cnt <= dly_cnt - 32'd1;
      end else begin
        addr <= addr + (en ? incr : '0) + (period_end ? shift : '0);
        if (period_end) begin
          per_cnt <= '0;
          if (iter_cnt == iter - 1'b1) begin
            busy <= 1'b0;
            done <= 1'b1;
          end else begin
            iter_cnt <= iter_cnt + 1'b1;
          end
        end else begin
          per_cnt <= per_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/lookup_table_write.sv
// Captures the in0 stream into a dual-port RAM and burst-writes it to external memory
// over databus port 0, optionally double-buffered so fill and flush overlap.
module lookup_table_write
  import lookup_table_write_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned AXI_ADDR_W = 32,
  parameter int unsigned AXI_DATA_W = 32,
  parameter int unsigned LEN_W      = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    run,
  input  logic                    running,
  input  logic                    disabled,
  input  logic [DATA_W-1:0]       in0,
  input  logic [31:0]             delay0,
  input  logic [AXI_ADDR_W-1:0]   ext_addr,
  input  logic [LEN_W-1:0]        length,
  input  logic [ADDR_W-1:0]       iterA,
  input  logic [ADDR_W-1:0]       perA,
  input  logic [ADDR_W-1:0]       dutyA,
  input  logic [ADDR_W-1:0]       shiftA,
  input  logic [ADDR_W-1:0]       incrA,
  input  logic                    pingPong,
  output logic                    databus_valid_0,
  input  logic                    databus_ready_0,
  output logic [AXI_ADDR_W-1:0]   databus_addr_0,
  output logic [AXI_DATA_W-1:0]   databus_wdata_0,
  output logic [AXI_DATA_W/8-1:0] databus_wstrb_0,
  output logic [LEN_W-1:0]        databus_len_0,
  input  logic                    databus_last_0,
  input  logic [AXI_DATA_W-1:0]   databus_rdata_0,
  output logic                    done,
  output logic [ADDR_W-1:0]       ext_dp_addr_0_port_0,
  output logic [AXI_DATA_W-1:0]   ext_dp_out_0_port_0,
  input  logic [AXI_DATA_W-1:0]   ext_dp_in_0_port_0,
  output logic                    ext_dp_enable_0_port_0,
  output logic                    ext_dp_write_0_port_0,
  output logic [ADDR_W-1:0]       ext_dp_addr_0_port_1,
  output logic [AXI_DATA_W-1:0]   ext_dp_out_0_port_1,
  input  logic [AXI_DATA_W-1:0]   ext_dp_in_0_port_1,
  output logic                    ext_dp_enable_0_port_1,
  output logic                    ext_dp_write_0_port_1
);

  localparam int unsigned OCC_W = FIFO_CNT_W + 1;

  flush_state_t              state;
  logic                      bank;
  logic [LEN_W-1:0]          rd_cnt;
  logic                      rd_pend;
  logic [AXI_DATA_W-1:0]     fifo_mem [FIFO_DEPTH];
  logic [FIFO_PTR_W-1:0]     fifo_wp;
  logic [FIFO_PTR_W-1:0]     fifo_rp;
  logic [FIFO_CNT_W-1:0]     fifo_cnt;

  logic                      start;
  logic                      pop;
  logic                      hs_last;
  logic                      rd_issue;
  logic [OCC_W-1:0]          occ;
  logic [ADDR_W-1:0]         gen_addr;
  logic [ADDR_W-1:0]         rd_addr;
  logic                      gen_en;
  logic                      gen_done;
  logic                      unused_inputs;

  assign unused_inputs = ^{databus_rdata_0, ext_dp_in_0_port_0};

  fill_addr_gen #(.ADDR_W(ADDR_W)) u_fill_addr_gen (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .running (running),
    .delay   (delay0),
    .iter    (iterA),
    .per     (perA),
    .duty    (dutyA),
    .shift   (shiftA),
    .incr    (incrA),
    .addr    (gen_addr),
    .en      (gen_en),
    .done    (gen_done)
  );

  // A read is issued only if its data, landing next cycle, still finds a free slot
  always_comb begin
    start    = run && !disabled;
    pop      = databus_valid_0 && databus_ready_0;
    hs_last  = pop && databus_last_0;
    occ      = OCC_W'(fifo_cnt) + OCC_W'(rd_pend) - OCC_W'(pop);
    rd_issue = (state == STREAM) && (rd_cnt < length) && (occ < OCC_W'(FIFO_DEPTH));
    rd_addr  = ADDR_W'(rd_cnt);
  end

  assign databus_valid_0 = (fifo_cnt != '0);
  assign databus_wdata_0 = fifo_mem[fifo_rp];
  assign databus_wstrb_0 = databus_valid_0 ? '1 : '0;
  assign databus_len_0   = length;

  assign ext_dp_addr_0_port_0   = pingPong ? {bank, gen_addr[ADDR_W-2:0]} : gen_addr;
  assign ext_dp_out_0_port_0    = in0;
  assign ext_dp_enable_0_port_0 = gen_en;
  assign ext_dp_write_0_port_0  = gen_en;

  assign ext_dp_addr_0_port_1   = pingPong ? {~bank, rd_addr[ADDR_W-2:0]} : rd_addr;
  assign ext_dp_out_0_port_1    = '0;
  assign ext_dp_enable_0_port_1 = rd_issue;
  assign ext_dp_write_0_port_1  = 1'b0;

  always_ff @(posedge clk) begin
    if (rd_pend) fifo_mem[fifo_wp] <= ext_dp_in_0_port_1;
  end

  // A new run always wins over a concurrent last handshake and restarts every counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      bank           <= 1'b0;
      rd_cnt         <= '0;
      rd_pend        <= 1'b0;
      fifo_wp        <= '0;
      fifo_rp        <= '0;
      fifo_cnt       <= '0;
      done           <= 1'b1;
      databus_addr_0 <= '0;
    end else begin
      if (run) bank <= pingPong ? ~bank : 1'b0;
      if (start) begin
        done           <= 1'b0;
        databus_addr_0 <= ext_addr;
        rd_cnt         <= '0;
        rd_pend        <= 1'b0;
        fifo_wp        <= '0;
        fifo_rp        <= '0;
        fifo_cnt       <= '0;
        if (pingPong) state <= (length == '0) ? IDLE : STREAM;
        else          state <= WAIT;
      end else begin
        rd_pend  <= rd_issue;
        if (rd_issue) rd_cnt <= rd_cnt + 1'b1;
        if (rd_pend)  fifo_wp <= fifo_wp + FIFO_PTR_W'(1);
        if (pop)      fifo_rp <= fifo_rp + FIFO_PTR_W'(1);
        fifo_cnt <= fifo_cnt + FIFO_CNT_W'(rd_pend) - FIFO_CNT_W'(pop);
        case (state)
          WAIT:    if (gen_done) state <= (length == '0) ? IDLE : STREAM;
          STREAM: begin
            if (hs_last) begin
              state    <= IDLE;
              rd_cnt   <= '0;
              rd_pend  <= 1'b0;
              fifo_wp  <= '0;
              fifo_rp  <= '0;
              fifo_cnt <= '0;
            end
          end
          default: state <= IDLE;
        endcase
        if (!done && gen_done && ((state == IDLE) || hs_last)) done <= 1'b1;
      end
    end
  end

endmodule
